// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures the period of one freq_div output (CLK_50/CLK_10/CLK_1) in CLK_in cycles
// and flags deviation from nominal. Define CLK_MON_DUTY_EN to also build the HIGH_CNT duty measurement.
module clk_div_monitor #(
  parameter int TOL     = 0,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK_in,
  input  logic       RST,
  input  logic       CLK_50,
  input  logic       CLK_10,
  input  logic       CLK_1,
  input  logic [1:0] SEL,
  input  logic       START,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] PERIOD,
`ifdef CLK_MON_DUTY_EN
  output logic [7:0] HIGH_CNT,
`endif
  output logic       ERR
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

  state_t     state_q;
  logic [2:0] prev_q;
  logic [1:0] selLat_q;
  logic [7:0] cnt_q;

  logic [2:0] riseVec;
  logic       rise;
  logic [7:0] nominal;
  logic [8:0] cnt_d;
  logic       timeoutHit;
  logic       periodErr;
  logic       dutyErr;

  // Absolute difference taken at 9 bits so nothing wraps before the tolerance compare.
  function automatic logic outOfTol(input logic [7:0] meas, input logic [7:0] nom);
    logic [8:0] diff;
    diff = (meas >= nom) ? ({1'b0, meas} - {1'b0, nom}) : ({1'b0, nom} - {1'b0, meas});
    return ({23'd0, diff} > TOL);
  endfunction

  always_comb begin
    riseVec = {CLK_1, CLK_10, CLK_50} & ~prev_q;
    rise    = 1'b0;
    nominal = 8'd100;
    case (selLat_q)
      2'd0:    begin rise = riseVec[0]; nominal = 8'd2;   end
      2'd1:    begin rise = riseVec[1]; nominal = 8'd10;  end
      default: begin rise = riseVec[2]; nominal = 8'd100; end
    endcase
    cnt_d      = {1'b0, cnt_q} + 9'd1;
    timeoutHit = (cnt_d >= 9'(TIMEOUT));
    periodErr  = outOfTol(cnt_q, nominal);
  end

`ifdef CLK_MON_DUTY_EN
  logic [7:0] high_q;
  logic [7:0] high_d;
  logic [7:0] halfNom;
  logic       chanIn;

  always_comb begin
    chanIn  = CLK_1;
    halfNom = 8'd50;
    case (selLat_q)
      2'd0:    begin chanIn = CLK_50; halfNom = 8'd1;  end
      2'd1:    begin chanIn = CLK_10; halfNom = 8'd5;  end
      default: begin chanIn = CLK_1;  halfNom = 8'd50; end
    endcase
    high_d = high_q + {7'd0, chanIn};
  end

  assign dutyErr = outOfTol(high_q, halfNom);

  // High-cycle counter runs alongside the period counter; the closing rise cycle is not counted.
  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      high_q   <= 8'd0;
      HIGH_CNT <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            high_q <= 8'd0;
            if (SEL == 2'd3) HIGH_CNT <= 8'd0;
          end
        end
        ARM: begin
          if (rise) high_q <= 8'd1;
          else if (timeoutHit) HIGH_CNT <= high_q;
        end
        MEASURE: begin
          if (rise || timeoutHit) HIGH_CNT <= high_q;
          else high_q <= high_d;
        end
        default: ;
      endcase
    end
  end
`else
  assign dutyErr = 1'b0;
`endif

  // Main FSM; results are only written on the transition into REPORT so they hold until the next accept.
  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      prev_q   <= 3'd0;
      selLat_q <= 2'd0;
      cnt_q    <= 8'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PERIOD   <= 8'd0;
      ERR      <= 1'b0;
    end else begin
      prev_q <= {CLK_1, CLK_10, CLK_50};
      DONE   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            selLat_q <= SEL;
            cnt_q    <= 8'd0;
            if (SEL == 2'd3) begin
              PERIOD  <= 8'd0;
              ERR     <= 1'b1;
              DONE    <= 1'b1;
              state_q <= REPORT;
            end else begin
              BUSY    <= 1'b1;
              state_q <= ARM;
            end
          end
        end
        ARM: begin
          if (rise) begin
            cnt_q   <= 8'd1;
            state_q <= MEASURE;
          end else if (timeoutHit) begin
            PERIOD  <= 8'd255;
            ERR     <= 1'b1;
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            state_q <= REPORT;
          end else begin
            cnt_q <= cnt_d[7:0];
          end
        end
        MEASURE: begin
          if (rise) begin
            PERIOD  <= cnt_q;
            ERR     <= periodErr | dutyErr;
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            state_q <= REPORT;
          end else if (timeoutHit) begin
            PERIOD  <= 8'd255;
            ERR     <= 1'b1;
            DONE    <= 1'b1;
            BUSY    <= 1'b0;
            state_q <= REPORT;
          end else begin
            cnt_q <= cnt_d[7:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Testbench for clk_div_monitor: programmable divided-clock waveforms feed two monitors (TOL=0 and TOL=2);
// results are compared against a period/duty model derived from the waveform parameters.
module tb_clk_div_monitor;

`ifdef CLK_MON_DUTY_EN
  localparam bit DutyEn = 1'b1;
`else
  localparam bit DutyEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       c50, c10, c1;
  logic [1:0] sel = 2'd0;
  logic       start = 1'b0;
  logic       busyA, doneA, errA, busyB, doneB, errB;
  logic [7:0] perA, perB;
`ifdef CLK_MON_DUTY_EN
  logic [7:0] highA, highB;
`endif

  int checks = 0;
  int failures = 0;

  // Waveform generator state: per-channel period, high cycles, phase counter, forced-low flag, restart request.
  int wPer[3];
  int wHi[3];
  int wCnt[3];
  bit wHold[3];
  bit wReload[3];

  always #5 clk = ~clk;

  clk_div_monitor #(.TOL(0), .TIMEOUT(255)) dutA (
    .CLK_in(clk), .RST(rst), .CLK_50(c50), .CLK_10(c10), .CLK_1(c1),
    .SEL(sel), .START(start), .BUSY(busyA), .DONE(doneA), .PERIOD(perA),
`ifdef CLK_MON_DUTY_EN
    .HIGH_CNT(highA),
`endif
    .ERR(errA));

  clk_div_monitor #(.TOL(2), .TIMEOUT(255)) dutB (
    .CLK_in(clk), .RST(rst), .CLK_50(c50), .CLK_10(c10), .CLK_1(c1),
    .SEL(sel), .START(start), .BUSY(busyB), .DONE(doneB), .PERIOD(perB),
`ifdef CLK_MON_DUTY_EN
    .HIGH_CNT(highB),
`endif
    .ERR(errB));

  // Waveforms advance 1 time unit after each rising edge so the DUT always samples settled data.
  always @(posedge clk) begin
    #1;
    for (int ch = 0; ch < 3; ch++) begin
      if (wReload[ch]) begin
        wCnt[ch] = 0;
        wReload[ch] = 1'b0;
      end else begin
        wCnt[ch] = (wCnt[ch] + 1 >= wPer[ch]) ? 0 : wCnt[ch] + 1;
      end
    end
    c50 = !wHold[0] && (wCnt[0] < wHi[0]);
    c10 = !wHold[1] && (wCnt[1] < wHi[1]);
    c1  = !wHold[2] && (wCnt[2] < wHi[2]);
  end

  // Reference: a periodic waveform of period P with H high cycles measures as PERIOD=P, HIGH_CNT=H.
  function automatic bit refErr(int ch, int per, int hi, int tol);
    int nom = (ch == 0) ? 2 : (ch == 1) ? 10 : 100;
    int dp = (per > nom) ? per - nom : nom - per;
    int dh = (hi > nom / 2) ? hi - nom / 2 : nom / 2 - hi;
    return (dp > tol) || (DutyEn && (dh > tol));
  endfunction

  task automatic setWave(input int ch, input int per, input int hi, input bit hold);
    wPer[ch] = per;
    wHi[ch] = hi;
    wHold[ch] = hold;
    wReload[ch] = 1'b1;
  endtask

  task automatic nominalWaves();
    setWave(0, 2, 1, 1'b0);
    setWave(1, 10, 5, 1'b0);
    setWave(2, 100, 50, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  // Pulses START for one cycle, then waits (bounded) for DONE; lat=1 means DONE in the cycle right after acceptance.
  task automatic runMeasure(input logic [1:0] s, input int limit, output bit gotDone, output int lat);
    @(negedge clk);
    sel = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gotDone = 1'b0;
    lat = 1;
    while (lat <= limit) begin
      if (doneA) begin
        gotDone = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busyA); end
    checks++; if (doneA !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", doneA); end
    checks++; if (perA !== 8'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", perA); end
    checks++; if (errA !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", errA); end
`ifdef CLK_MON_DUTY_EN
    checks++; if (highA !== 8'd0) begin failures++; $display("FAIL reset_high got=%0d exp=0", highA); end
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    int nomPer[3] = '{2, 10, 100};
    int maxLat[3] = '{5, 22, 202};
    bit got;
    int lat;
    for (int s = 0; s < 3; s++) begin
      runMeasure(2'(s), maxLat[s] + 10, got, lat);
      checks++; if (!got) begin failures++; $display("FAIL nominal_done sel=%0d no DONE within bound", s); end
      checks++; if (lat > maxLat[s]) begin failures++; $display("FAIL nominal_latency sel=%0d got=%0d exp<=%0d", s, lat, maxLat[s]); end
      checks++; if (perA !== 8'(nomPer[s])) begin failures++; $display("FAIL nominal_period sel=%0d got=%0d exp=%0d", s, perA, nomPer[s]); end
      checks++; if (errA !== 1'b0) begin failures++; $display("FAIL nominal_err sel=%0d got=%b exp=0", s, errA); end
      checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL nominal_busy_at_done sel=%0d got=%b exp=0", s, busyA); end
`ifdef CLK_MON_DUTY_EN
      checks++; if (highA !== 8'(nomPer[s] / 2)) begin failures++; $display("FAIL nominal_high sel=%0d got=%0d exp=%0d", s, highA, nomPer[s] / 2); end
`endif
    end
  endtask

  task automatic test_div12();
    bit got;
    int lat;
    setWave(1, 12, 6, 1'b0);
    repeat (3) @(negedge clk);
    runMeasure(2'd1, 40, got, lat);
    checks++; if (!got) begin failures++; $display("FAIL div12_done no DONE within bound"); end
    checks++; if (perA !== 8'd12) begin failures++; $display("FAIL div12_period got=%0d exp=12", perA); end
    checks++; if (errA !== refErr(1, 12, 6, 0)) begin failures++; $display("FAIL div12_err_tol0 got=%b exp=%b", errA, refErr(1, 12, 6, 0)); end
    checks++; if (errB !== refErr(1, 12, 6, 2)) begin failures++; $display("FAIL div12_err_tol2 got=%b exp=%b", errB, refErr(1, 12, 6, 2)); end
    nominalWaves();
  endtask

  task automatic test_timeout();
    bit got;
    int lat;
    setWave(2, 100, 50, 1'b1);
    repeat (3) @(negedge clk);
    runMeasure(2'd2, 300, got, lat);
    checks++; if (!got) begin failures++; $display("FAIL timeout_done no DONE within 300 cycles"); end
    checks++; if (lat < 255 || lat > 257) begin failures++; $display("FAIL timeout_latency got=%0d exp=255..257", lat); end
    checks++; if (perA !== 8'd255) begin failures++; $display("FAIL timeout_period got=%0d exp=255", perA); end
    checks++; if (errA !== 1'b1 || errB !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b/%b exp=1/1", errA, errB); end
    nominalWaves();
  endtask

  task automatic test_reserved();
    bit got;
    int lat;
    runMeasure(2'd3, 5, got, lat);
    checks++; if (!got || lat != 1) begin failures++; $display("FAIL reserved_latency got=%0d exp=1", lat); end
    checks++; if (perA !== 8'd0) begin failures++; $display("FAIL reserved_period got=%0d exp=0", perA); end
    checks++; if (errA !== 1'b1) begin failures++; $display("FAIL reserved_err got=%b exp=1", errA); end
    checks++; if (busyA !== 1'b0) begin failures++; $display("FAIL reserved_busy got=%b exp=0", busyA); end
  endtask

  task automatic test_ignore_start();
    bit got = 1'b0;
    @(negedge clk);
    sel = 2'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL ignore_busy_after_accept got=%b exp=1", busyA); end
    repeat (3) @(negedge clk);
    sel = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sel = 2'd3;
    for (int i = 0; i < 40 && !got; i++) begin
      if (doneA) got = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!got) begin failures++; $display("FAIL ignore_done no DONE within bound"); end
    checks++; if (perA !== 8'd10) begin failures++; $display("FAIL ignore_period got=%0d exp=10", perA); end
    checks++; if (errA !== 1'b0) begin failures++; $display("FAIL ignore_err got=%b exp=0", errA); end
  endtask

  task automatic test_back_to_back();
    bit got;
    int lat;
    runMeasure(2'd0, 10, got, lat);
    checks++; if (!got) begin failures++; $display("FAIL b2b_first_done no DONE within bound"); end
    sel = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (doneA !== 1'b0 || busyA !== 1'b0) begin failures++; $display("FAIL b2b_start_on_done done=%b busy=%b exp=0/0", doneA, busyA); end
    checks++; if (perA !== 8'd2) begin failures++; $display("FAIL b2b_hold_period got=%0d exp=2", perA); end
    runMeasure(2'd3, 5, got, lat);
    checks++; if (!got || lat != 1) begin failures++; $display("FAIL b2b_next_start latency got=%0d exp=1", lat); end
  endtask

  task automatic test_random();
    bit got;
    int lat, ch, per, hi;
    int maxPer[3] = '{8, 30, 200};
    for (int n = 0; n < 8; n++) begin
      ch = $urandom_range(0, 2);
      per = $urandom_range(2, maxPer[ch]);
      hi = $urandom_range(1, per - 1);
      setWave(ch, per, hi, 1'b0);
      repeat ($urandom_range(2, 6)) @(negedge clk);
      runMeasure(2'(ch), 2 * per + 8, got, lat);
      checks++; if (!got || lat < per + 2 || lat > 2 * per + 1) begin failures++; $display("FAIL random_latency ch=%0d per=%0d got=%0d exp=%0d..%0d", ch, per, lat, per + 2, 2 * per + 1); end
      checks++; if (perA !== 8'(per)) begin failures++; $display("FAIL random_period ch=%0d got=%0d exp=%0d", ch, perA, per); end
      checks++; if (errA !== refErr(ch, per, hi, 0)) begin failures++; $display("FAIL random_err_tol0 ch=%0d per=%0d hi=%0d got=%b exp=%b", ch, per, hi, errA, refErr(ch, per, hi, 0)); end
      checks++; if (errB !== refErr(ch, per, hi, 2)) begin failures++; $display("FAIL random_err_tol2 ch=%0d per=%0d hi=%0d got=%b exp=%b", ch, per, hi, errB, refErr(ch, per, hi, 2)); end
`ifdef CLK_MON_DUTY_EN
      checks++; if (highA !== 8'(hi)) begin failures++; $display("FAIL random_high ch=%0d got=%0d exp=%0d", ch, highA, hi); end
`endif
      nominalWaves();
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    bit sawDone = 1'b0;
    int lat;
    @(negedge clk);
    sel = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (120) @(negedge clk);
    checks++; if (busyA !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busyA); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busyA !== 1'b0 || doneA !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl busy=%b done=%b exp=0/0", busyA, doneA); end
    checks++; if (perA !== 8'd0 || errA !== 1'b0) begin failures++; $display("FAIL rstmid_result period=%0d err=%b exp=0/0", perA, errA); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (doneA) sawDone = 1'b1;
    end
    checks++; if (sawDone) begin failures++; $display("FAIL rstmid_no_done got=1 exp=0"); end
    runMeasure(2'd2, 210, got, lat);
    checks++; if (!got || perA !== 8'd100) begin failures++; $display("FAIL rstmid_rerun_period got=%0d exp=100", perA); end
    checks++; if (errA !== 1'b0) begin failures++; $display("FAIL rstmid_rerun_err got=%b exp=0", errA); end
  endtask

  initial begin
    setWave(0, 2, 1, 1'b0);
    setWave(1, 10, 5, 1'b0);
    setWave(2, 100, 50, 1'b0);
    for (int ch = 0; ch < 3; ch++) begin
      wReload[ch] = 1'b0;
      wCnt[ch] = $urandom_range(0, wPer[ch] - 1);
    end
    c50 = 1'b0;
    c10 = 1'b0;
    c1 = 1'b0;
    $display("[TB] starting clk_div_monitor bench (duty=%0d)", DutyEn);
    test_reset();
    test_nominal();
    test_div12();
    test_timeout();
    test_reserved();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
